i2c_req_arbiter: RTL

- Shares one single-byte I2C master engine between two independent requesters.
- Each requester issues either a 1-byte register write or a 1-byte register read.
- Arbitrates round-robin, latches the winner's command, launches the engine, and tracks its busy flag to completion.
- Recovers a hung engine (e.g. slave never ACKs) with a watchdog-driven engine reset, and reports completion or error back to the owning requester.

---
 rtl/i2c_req_arbiter_if.sv | 52 +++++
 rtl/i2c_req_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/i2c_req_arbiter_if.sv
// rtl/i2c_req_arbiter_if.sv - requester and engine signal bundle for the I2C request arbiter
interface i2c_req_arbiter_if;
    // requester 0
    logic       req0_i;
    logic       req0_wr_i;
    logic [2:0] req0_dev_i;
    logic [7:0] req0_word_i;
    logic [7:0] req0_wdata_i;
    logic       ack0_o;
    logic       done0_o;
    logic       err0_o;
    // requester 1
    logic       req1_i;
    logic       req1_wr_i;
    logic [2:0] req1_dev_i;
    logic [7:0] req1_word_i;
    logic [7:0] req1_wdata_i;
    logic       ack1_o;
    logic       done1_o;
    logic       err1_o;
    // shared read result
    logic [7:0] rd_data_o;
    // engine side
    logic [2:0] eng_dev_o;
    logic [7:0] eng_word_o;
    logic [7:0] eng_wdata_o;
    logic       eng_wr_start_o;
    logic       eng_rd_start_o;
    logic       eng_busy_i;
    logic [7:0] eng_rd_data_i;
    logic       eng_rst_n_o;

    // arbiter side
    modport slave (
        input  req0_i, req0_wr_i, req0_dev_i, req0_word_i, req0_wdata_i,
        input  req1_i, req1_wr_i, req1_dev_i, req1_word_i, req1_wdata_i,
        input  eng_busy_i, eng_rd_data_i,
        output ack0_o, done0_o, err0_o, ack1_o, done1_o, err1_o, rd_data_o,
        output eng_dev_o, eng_word_o, eng_wdata_o,
        output eng_wr_start_o, eng_rd_start_o, eng_rst_n_o
    );

    // requesters plus engine side
    modport master (
        output req0_i, req0_wr_i, req0_dev_i, req0_word_i, req0_wdata_i,
        output req1_i, req1_wr_i, req1_dev_i, req1_word_i, req1_wdata_i,
        output eng_busy_i, eng_rd_data_i,
        input  ack0_o, done0_o, err0_o, ack1_o, done1_o, err1_o, rd_data_o,
        input  eng_dev_o, eng_word_o, eng_wdata_o,
        input  eng_wr_start_o, eng_rd_start_o, eng_rst_n_o
    );
endinterface

// File: rtl/i2c_req_arbiter.sv
// rtl/i2c_req_arbiter.sv - round-robin sharing of one single-byte I2C engine with watchdog recovery
module i2c_req_arbiter #(
    parameter int TIMEOUT_CYC = 4096,
    parameter int START_CYC   = 8,
    parameter int RECOVER_CYC = 16
) (
    input  logic             sys_clk_i,
    input  logic             rst_i,
    i2c_req_arbiter_if.slave bus
);

    localparam int TOT_W   = ($clog2(TIMEOUT_CYC) > 0) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int START_W = ($clog2(START_CYC)   > 0) ? $clog2(START_CYC)   : 1;
    localparam int REC_W   = ($clog2(RECOVER_CYC) > 0) ? $clog2(RECOVER_CYC) : 1;

    localparam logic [TOT_W-1:0]   TOT_LAST   = TOT_W'(TIMEOUT_CYC - 1);
    localparam logic [START_W-1:0] START_LAST = START_W'(START_CYC - 1);
    localparam logic [REC_W-1:0]   REC_LAST   = REC_W'(RECOVER_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        RUN,
        RECOVER
    } state_t;

    state_t             state;
    logic               last_grant;
    logic               owner;
    logic               cmd_wr;
    logic [TOT_W-1:0]   tot_cnt;
    logic [START_W-1:0] start_cnt;
    logic [REC_W-1:0]   rec_cnt;

    logic       ack0_q, ack1_q, done0_q, done1_q, err0_q, err1_q;
    logic       wr_start_q, rd_start_q, eng_rst_n_q;
    logic [2:0] dev_q;
    logic [7:0] word_q, wdata_q, rd_data_q;

    logic       grant_valid;
    logic       grant_sel;
    logic       sel_wr;
    logic [2:0] sel_dev;
    logic [7:0] sel_word;
    logic [7:0] sel_wdata;

    // Winner selection: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        grant_valid = bus.req0_i | bus.req1_i;
        grant_sel   = (bus.req0_i & bus.req1_i) ? ~last_grant : bus.req1_i;
        sel_wr      = grant_sel ? bus.req1_wr_i    : bus.req0_wr_i;
        sel_dev     = grant_sel ? bus.req1_dev_i   : bus.req0_dev_i;
        sel_word    = grant_sel ? bus.req1_word_i  : bus.req0_word_i;
        sel_wdata   = grant_sel ? bus.req1_wdata_i : bus.req0_wdata_i;
    end

    // Transaction FSM with registered pulses, command latch and watchdog counters.
    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            owner       <= 1'b0;
            cmd_wr      <= 1'b0;
            tot_cnt     <= '0;
            start_cnt   <= '0;
            rec_cnt     <= '0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            err0_q      <= 1'b0;
            err1_q      <= 1'b0;
            wr_start_q  <= 1'b0;
            rd_start_q  <= 1'b0;
            eng_rst_n_q <= 1'b0;
            dev_q       <= '0;
            word_q      <= '0;
            wdata_q     <= '0;
            rd_data_q   <= '0;
        end else begin
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            err0_q      <= 1'b0;
            err1_q      <= 1'b0;
            wr_start_q  <= 1'b0;
            rd_start_q  <= 1'b0;
            eng_rst_n_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner      <= grant_sel;
                        cmd_wr     <= sel_wr;
                        dev_q      <= sel_dev;
                        word_q     <= sel_word;
                        wdata_q    <= sel_wdata;
                        ack0_q     <= ~grant_sel;
                        ack1_q     <= grant_sel;
                        last_grant <= grant_sel;
                        state      <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    wr_start_q <= cmd_wr;
                    rd_start_q <= ~cmd_wr;
                    tot_cnt    <= '0;
                    start_cnt  <= '0;
                    state      <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tot_cnt != TOT_LAST)     tot_cnt   <= tot_cnt + 1'b1;
                    if (start_cnt != START_LAST) start_cnt <= start_cnt + 1'b1;
                    if (bus.eng_busy_i) begin
                        state <= RUN;
                    end else if (start_cnt == START_LAST) begin
                        eng_rst_n_q <= 1'b0;
                        rec_cnt     <= '0;
                        state       <= RECOVER;
                    end
                end
                RUN: begin
                    if (tot_cnt != TOT_LAST) tot_cnt <= tot_cnt + 1'b1;
                    if (!bus.eng_busy_i) begin
                        done0_q <= ~owner;
                        done1_q <= owner;
                        if (!cmd_wr) rd_data_q <= bus.eng_rd_data_i;
                        state <= IDLE;
                    end else if (tot_cnt == TOT_LAST) begin
                        eng_rst_n_q <= 1'b0;
                        rec_cnt     <= '0;
                        state       <= RECOVER;
                    end
                end
                RECOVER: begin
                    if (rec_cnt == REC_LAST) begin
                        err0_q <= ~owner;
                        err1_q <= owner;
                        state  <= IDLE;
                    end else begin
                        eng_rst_n_q <= 1'b0;
                        rec_cnt     <= rec_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ack0_o         = ack0_q;
    assign bus.ack1_o         = ack1_q;
    assign bus.done0_o        = done0_q;
    assign bus.done1_o        = done1_q;
    assign bus.err0_o         = err0_q;
    assign bus.err1_o         = err1_q;
    assign bus.rd_data_o      = rd_data_q;
    assign bus.eng_dev_o      = dev_q;
    assign bus.eng_word_o     = word_q;
    assign bus.eng_wdata_o    = wdata_q;
    assign bus.eng_wr_start_o = wr_start_q;
    assign bus.eng_rd_start_o = rd_start_q;
    assign bus.eng_rst_n_o    = eng_rst_n_q;

endmodule
